// File: rtl/ecc_scrub_arbiter_if.sv
// Host access port and SRAM access port of the ECC scrub arbiter.
// slave = arbiter side, master = host/SRAM side.
interface ecc_scrub_arbiter_if #(
    parameter int AW = 10
);
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [31:0]   host_rdata;
    logic          host_err;

    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [31:0]   mem_wdata;
    logic          mem_r_en;
    logic [AW-1:0] mem_r_addr;
    logic [31:0]   mem_rdata;
    logic          mem_sgl;
    logic          mem_dbl;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_err,
        output mem_w_en, mem_w_addr, mem_wdata, mem_r_en, mem_r_addr,
        input  mem_rdata, mem_sgl, mem_dbl
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_err,
        input  mem_w_en, mem_w_addr, mem_wdata, mem_r_en, mem_r_addr,
        output mem_rdata, mem_sgl, mem_dbl
    );
endinterface

// File: rtl/ecc_scrub_arbiter.sv
// Shares one SECDED SRAM slot between host and a background scrubber that corrects/logs errors.
// Latency: host write 0, host read 2 cycles grant->rvalid; backpressure: host_req held until host_gnt, scrub wins after MAX_DEFER deferrals.
module ecc_scrub_arbiter #(
    parameter int AW             = 10,
    parameter int DEPTH          = 1024,
    parameter int SCRUB_INTERVAL = 64,
    parameter int MAX_DEFER      = 8,
    parameter int CW             = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_scrub_arbiter_if.slave   bus,
    input  logic                 scrub_en,
    output logic [CW-1:0]        sgl_cnt,
    output logic [CW-1:0]        dbl_cnt,
    output logic [AW-1:0]        dbl_addr,
    output logic                 pass_done
);
    localparam int IW = $clog2(SCRUB_INTERVAL);
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam logic [IW-1:0] INT_LAST  = IW'(SCRUB_INTERVAL - 1);
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, HOST_RD, SCRUB_CHK, SCRUB_WB} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] scrub_addr;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] int_cnt;
    logic [DW-1:0] defer_cnt;
    logic          scrub_pending;
    logic [31:0]   wb_data;

    logic          scrub_win;
    logic          advance;
    logic          dbl_evt;
    logic [AW-1:0] dbl_evt_addr;

    always_comb begin
        state_nxt       = state;
        scrub_win       = 1'b0;
        advance         = 1'b0;
        bus.host_gnt    = 1'b0;
        bus.mem_w_en    = 1'b0;
        bus.mem_w_addr  = scrub_addr;
        bus.mem_wdata   = wb_data;
        bus.mem_r_en    = 1'b0;
        bus.mem_r_addr  = scrub_addr;
        case (state)
            IDLE: begin
                // Reset forces IDLE asynchronously, so only this state needs gating.
                if (!rst) begin
                    scrub_win = scrub_pending && (!bus.host_req || defer_cnt == DEFER_MAX);
                    if (scrub_win) begin
                        bus.mem_r_en = 1'b1;
                        state_nxt    = SCRUB_CHK;
                    end else if (bus.host_req) begin
                        bus.host_gnt = 1'b1;
                        if (bus.host_we) begin
                            bus.mem_w_en   = 1'b1;
                            bus.mem_w_addr = bus.host_addr;
                            bus.mem_wdata  = bus.host_wdata;
                        end else begin
                            bus.mem_r_en   = 1'b1;
                            bus.mem_r_addr = bus.host_addr;
                            state_nxt      = HOST_RD;
                        end
                    end
                end
            end
            HOST_RD: state_nxt = IDLE;
            SCRUB_CHK: begin
                if (bus.mem_dbl) begin
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.mem_sgl) begin
                    state_nxt = SCRUB_WB;
                end else begin
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SCRUB_WB: begin
                bus.mem_w_en = 1'b1;
                advance      = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbl_evt      = bus.mem_dbl && (state == HOST_RD || state == SCRUB_CHK);
    assign dbl_evt_addr = (state == HOST_RD) ? rd_addr : scrub_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.host_rvalid <= 1'b0;
            bus.host_rdata  <= '0;
            bus.host_err    <= 1'b0;
            rd_addr         <= '0;
            wb_data         <= '0;
            scrub_addr      <= '0;
            sgl_cnt         <= '0;
            dbl_cnt         <= '0;
            dbl_addr        <= '0;
            pass_done       <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.host_rvalid <= (state == HOST_RD);
            if (state == HOST_RD) begin
                bus.host_rdata <= bus.mem_rdata;
                bus.host_err   <= bus.mem_dbl;
            end
            if (bus.host_gnt && !bus.host_we) begin
                rd_addr <= bus.host_addr;
            end
            if (state == SCRUB_CHK && !bus.mem_dbl && bus.mem_sgl) begin
                wb_data <= bus.mem_rdata;
                if (sgl_cnt != CNT_MAX) sgl_cnt <= sgl_cnt + 1'b1;
            end
            if (dbl_evt) begin
                dbl_addr <= dbl_evt_addr;
                if (dbl_cnt != CNT_MAX) dbl_cnt <= dbl_cnt + 1'b1;
            end
            pass_done <= advance && (scrub_addr == ADDR_LAST);
            if (advance) begin
                scrub_addr <= (scrub_addr == ADDR_LAST) ? '0 : scrub_addr + 1'b1;
            end
        end
    end

    // A tick landing while a scrub is already pending is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_cnt       <= '0;
            defer_cnt     <= '0;
            scrub_pending <= 1'b0;
        end else if (!scrub_en) begin
            int_cnt       <= '0;
            defer_cnt     <= '0;
            scrub_pending <= 1'b0;
        end else begin
            int_cnt <= (int_cnt == INT_LAST) ? '0 : int_cnt + 1'b1;
            if (scrub_win) begin
                scrub_pending <= 1'b0;
                defer_cnt     <= '0;
            end else begin
                if (int_cnt == INT_LAST) scrub_pending <= 1'b1;
                if (bus.host_gnt && scrub_pending) defer_cnt <= defer_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/ecc_scrub_arbiter.md
Name: ecc_scrub_arbiter

Overview:
- Controller in front of the SECDED-protected 32-bit SRAM: the ECC write/read datapath with single/double error flags.
- Shares the single SRAM access slot between a host port and an internal background scrubber.
- The scrubber periodically reads each address, writes back corrected data on single-bit errors, and counts and logs double-bit errors.
- Host accesses have priority; a bounded-deferral rule prevents scrubber starvation.

Parameters:
AW, 10, address width
DEPTH, 1024, number of words scrubbed (addresses 0..DEPTH-1)
SCRUB_INTERVAL, 64, cycles between scrub requests while scrub_en=1 (>=2)
MAX_DEFER, 8, host grants allowed while a scrub is pending before the scrub wins (>=1)
CW, 16, width of error counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
host_req  in  1  host access request (level; held until host_gnt)
host_we  in  1  1=write, 0=read
host_addr  in  AW  host address
host_wdata  in  32  host write data
host_gnt  out  1  combinational; access accepted this cycle
host_rvalid  out  1  registered one-cycle pulse; read data valid
host_rdata  out  32  registered corrected read data
host_err  out  1  registered; uncorrectable error on this read (valid with host_rvalid)
scrub_en  in  1  enables background scrubbing
mem_w_en  out  1  combinational SRAM write enable
mem_w_addr  out  AW  SRAM write address
mem_wdata  out  32  SRAM write data (ECC encoded downstream)
mem_r_en  out  1  combinational SRAM read enable
mem_r_addr  out  AW  SRAM read address
mem_rdata  in  32  corrected read data, valid one cycle after mem_r_en
mem_sgl  in  1  single-bit error flag, same timing as mem_rdata
mem_dbl  in  1  double-bit error flag, same timing as mem_rdata
sgl_cnt  out  CW  saturating count of corrected errors found by scrub
dbl_cnt  out  CW  saturating count of uncorrectable errors (scrub and host reads)
dbl_addr  out  AW  address of the most recent uncorrectable error
pass_done  out  1  registered one-cycle pulse when the scrub address wraps DEPTH-1 -> 0

Behaviour:
- Reset (async):
  - State=IDLE; all registered outputs, scrub_addr, interval counter, defer counter and scrub_pending are 0.
  - Combinational outputs are low because state is IDLE and no grant is possible during reset.
  - An in-flight sequence is abandoned; no writeback is issued.
- FSM states:
  - IDLE: the only state that grants.
  - HOST_RD: consumes mem_rdata.
  - SCRUB_CHK: examines the scrub read result.
  - SCRUB_WB: writes back the corrected word.
- Arbitration in IDLE:
  - scrub_win = scrub_pending & (!host_req | defer_cnt==MAX_DEFER).
  - If scrub_win: mem_r_en=1, mem_r_addr=scrub_addr, clear scrub_pending and defer_cnt, go to SCRUB_CHK.
  - Else if host_req: host_gnt=1.
    - Write: mem_w_en=1 with host_addr/host_wdata; stay IDLE.
    - Read: mem_r_en=1 at host_addr; go to HOST_RD.
    - If scrub_pending, defer_cnt++.
- HOST_RD: register host_rdata<=mem_rdata and host_err<=mem_dbl; host_rvalid=1 next cycle. If mem_dbl: dbl_cnt++, dbl_addr<=host read address. Go to IDLE. Host read latency is 2 cycles from grant to rvalid.
- SCRUB_CHK, by priority:
  - mem_dbl: dbl_cnt++, dbl_addr<=scrub_addr, no writeback, advance address, go to IDLE.
  - mem_sgl: latch mem_rdata, sgl_cnt++, go to SCRUB_WB.
  - Neither: advance address, go to IDLE.
- SCRUB_WB: mem_w_en=1 at scrub_addr with the latched data; advance address; go to IDLE.
- Atomicity: the read-check-writeback sequence is atomic. host_gnt=0 outside IDLE, so no host write can interleave with a scrub correction.
- Address advance: scrub_addr increments; at DEPTH-1 it wraps to 0 and pass_done pulses.
- Interval counter:
  - Counts while scrub_en=1; at SCRUB_INTERVAL-1 it sets scrub_pending and restarts from 0.
  - A tick while already pending is dropped; there is no queue.
- scrub_en=0: clears the interval counter, scrub_pending and defer_cnt. An in-flight scrub sequence completes. scrub_addr holds.
- Counters saturate at 2^CW-1.
- Simultaneous DBL from host and scrub is impossible, since only one read is outstanding at a time.

Test Plan:
- Host write addr 1 = 10, then read addr 1 (mem returns 10, sgl=dbl=0) -> host_gnt in the issue cycle; host_rvalid 2 cycles after grant with host_rdata=10, host_err=0.
- scrub_en=1, no host traffic, SCRUB_INTERVAL=64 -> scrub read of addr 0 issued 64 cycles after enable, addr 1 after 128 cycles; no mem_w_en when the flags are clean.
- Scrub read of addr 3 returns mem_sgl=1, rdata=30 -> next cycle mem_w_en=1, mem_w_addr=3, mem_wdata=30; sgl_cnt=1; host_gnt held 0 throughout despite host_req=1.
- Scrub read of addr 5 returns mem_dbl=1 -> no writeback; dbl_cnt=1, dbl_addr=5. A host read of addr 6 with mem_dbl=1 gives host_err=1, dbl_cnt=2, dbl_addr=6.
- host_req held continuously with a scrub pending and MAX_DEFER=8 -> exactly 8 host grants, then one scrub read, then host grants resume.
- DEPTH=4, run a full pass -> pass_done pulses once as scrub_addr wraps 3->0. Assert rst mid-SCRUB_WB -> no write issued, all outputs 0 immediately.
